lens_slot_manager: RTL and testbench

- Parametrised successor to the single-cursor lens selector.
- Holds an N_SLOTS lens table of centre x/y, radius R and strength K.
- Adds an in-place SELECT/edit mode for stored lenses, delete-with-compaction, undo-last and a configurable auto-repeat accelerator.
- Sits between the debounced board buttons/switches and the lens filter datapath; drives the preview cursor and the flattened lens table.

---
 rtl/lens_slot_manager.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_lens_slot_manager.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lens_slot_manager.sv
// Lens table manager: cursor editing, slot store/select/edit, delete-with-compaction, auto-repeat.
// Button actions take effect one cycle after the press edge; compaction takes (count-1-idx)+1 cycles and ignores buttons meanwhile.
module lens_slot_manager #(
   parameter int IMG_W   = 320,
   parameter int IMG_H   = 240,
   parameter int X_W     = 9,
   parameter int Y_W     = 8,
   parameter int N_SLOTS = 8,
   parameter int CNT_W   = $clog2(N_SLOTS + 1),
   parameter int R_MIN   = 5,
   parameter int R_MAX   = 120,
   parameter int K_MIN   = 1,
   parameter int K_MAX   = 200,
   parameter int DEF_R   = 30,
   parameter int DEF_K   = 40,
   parameter int REP_T0  = 2_000_000,
   parameter int REP_T1  = 1_000_000,
   parameter int REP_T2  = 500_000,
   parameter int HOLD1   = 50_000_000,
   parameter int HOLD2   = 150_000_000
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         edit_en,
   input  logic                         sel_mode,
   input  logic [1:0]                   field_sel,
   input  logic                         btn_u,
   input  logic                         btn_d,
   input  logic                         btn_l,
   input  logic                         btn_r,
   input  logic                         btn_c,
   input  logic                         btn_del,
   output logic [X_W-1:0]               cur_x,
   output logic [Y_W-1:0]               cur_y,
   output logic [7:0]                   cur_r,
   output logic [7:0]                   cur_k,
   output logic                         preview_en,
   output logic [$clog2(N_SLOTS)-1:0]   sel_idx,
   output logic [CNT_W-1:0]             lens_count,
   output logic [N_SLOTS*X_W-1:0]       lens_x,
   output logic [N_SLOTS*Y_W-1:0]       lens_y,
   output logic [N_SLOTS*8-1:0]         lens_r,
   output logic [N_SLOTS*8-1:0]         lens_k,
   output logic                         full,
   output logic                         busy
);

   localparam int SEL_W   = $clog2(N_SLOTS);
   localparam int REP_MAX = (REP_T0 > REP_T1) ? ((REP_T0 > REP_T2) ? REP_T0 : REP_T2)
                                              : ((REP_T1 > REP_T2) ? REP_T1 : REP_T2);
   localparam int REP_W   = $clog2(REP_MAX + 1);
   localparam int HOLD_W  = $clog2(HOLD2 + 1);

   localparam logic [X_W-1:0] DEF_X = X_W'(IMG_W / 2);
   localparam logic [Y_W-1:0] DEF_Y = Y_W'(IMG_H / 2);
   localparam logic [X_W-1:0] X_HI  = X_W'(IMG_W - 1);
   localparam logic [Y_W-1:0] Y_HI  = Y_W'(IMG_H - 1);
   localparam logic [7:0]     R_LO  = 8'(R_MIN);
   localparam logic [7:0]     R_HI  = 8'(R_MAX);
   localparam logic [7:0]     K_LO  = 8'(K_MIN);
   localparam logic [7:0]     K_HI  = 8'(K_MAX);
   localparam logic [7:0]     R_DEF = 8'(DEF_R);
   localparam logic [7:0]     K_DEF = 8'(DEF_K);

   typedef enum logic [1:0] {S_IDLE, S_ADD, S_SELECT, S_COMPACT} state_t;

   state_t state;

   logic [X_W-1:0] slot_x [N_SLOTS];
   logic [Y_W-1:0] slot_y [N_SLOTS];
   logic [7:0]     slot_r [N_SLOTS];
   logic [7:0]     slot_k [N_SLOTS];

   logic [X_W-1:0] cur_x_q;
   logic [Y_W-1:0] cur_y_q;
   logic [7:0]     cur_r_q;
   logic [7:0]     cur_k_q;
   logic [SEL_W-1:0] ptr;

   logic [5:0] btn_now, btn_q, rise;
   logic       edit_q, edit_rise, edit_fall;
   logic       dir_held, dir_rise, rep_tick;
   logic [3:0] step;
   logic       up, dn, lf, rt;
   logic [HOLD_W-1:0] hold_cnt;
   logic [REP_W-1:0]  rep_cnt, period;

   logic [X_W-1:0] ed_x;
   logic [Y_W-1:0] ed_y;
   logic [7:0]     ed_r, ed_k;

   logic [CNT_W-1:0] cnt_m1, add_cnt_nxt, sel_ext, ptr_ext;
   logic [SEL_W-1:0] cnt_lo, cnt_last;
   logic             del_ok, c_ok;

   assign btn_now   = {btn_del, btn_c, btn_r, btn_l, btn_d, btn_u};
   assign rise      = btn_now & ~btn_q;
   assign edit_rise = edit_en & ~edit_q;
   assign edit_fall = ~edit_en & edit_q;
   assign dir_held  = |btn_now[3:0];
   assign dir_rise  = |rise[3:0];

   always_comb begin
      if (hold_cnt < HOLD_W'(HOLD1))
         period = REP_W'(REP_T0);
      else if (hold_cnt < HOLD_W'(HOLD2))
         period = REP_W'(REP_T1);
      else
         period = REP_W'(REP_T2);
   end

   // >= rather than == so a period shrink mid-count still fires promptly
   assign rep_tick = dir_held & ~dir_rise & (rep_cnt >= period - REP_W'(1));
   assign step     = rise[3:0] | ({4{rep_tick}} & btn_now[3:0]);
   assign up = step[0];
   assign dn = step[1];
   assign lf = step[2];
   assign rt = step[3];

   assign cur_x = (state == S_SELECT) ? slot_x[sel_idx] : cur_x_q;
   assign cur_y = (state == S_SELECT) ? slot_y[sel_idx] : cur_y_q;
   assign cur_r = (state == S_SELECT) ? slot_r[sel_idx] : cur_r_q;
   assign cur_k = (state == S_SELECT) ? slot_k[sel_idx] : cur_k_q;

   always_comb begin
      ed_x = cur_x;
      ed_y = cur_y;
      ed_r = cur_r;
      ed_k = cur_k;
      case (field_sel)
         2'd0: begin
            if (lf) begin
               if (cur_x != '0) ed_x = cur_x - X_W'(1);
            end else if (rt) begin
               if (cur_x < X_HI) ed_x = cur_x + X_W'(1);
            end
            if (up) begin
               if (cur_y != '0) ed_y = cur_y - Y_W'(1);
            end else if (dn) begin
               if (cur_y < Y_HI) ed_y = cur_y + Y_W'(1);
            end
         end
         2'd1: begin
            if (up) begin
               if (cur_r < R_HI) ed_r = cur_r + 8'd1;
            end else if (dn) begin
               if (cur_r > R_LO) ed_r = cur_r - 8'd1;
            end
         end
         2'd2: begin
            if (up) begin
               if (cur_k < K_HI) ed_k = cur_k + 8'd1;
            end else if (dn) begin
               if (cur_k > K_LO) ed_k = cur_k - 8'd1;
            end
         end
         default: ;
      endcase
   end

   assign full     = (lens_count == CNT_W'(N_SLOTS));
   assign cnt_m1   = lens_count - CNT_W'(1);
   assign cnt_lo   = SEL_W'(lens_count);
   assign cnt_last = SEL_W'(cnt_m1);
   assign sel_ext  = CNT_W'(sel_idx);
   assign ptr_ext  = CNT_W'(ptr);
   assign del_ok   = rise[5] & (lens_count != '0);
   assign c_ok     = rise[4] & ~full;

   always_comb begin
      add_cnt_nxt = lens_count;
      if (del_ok)
         add_cnt_nxt = cnt_m1;
      else if (c_ok)
         add_cnt_nxt = lens_count + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         lens_count <= '0;
         sel_idx    <= '0;
         ptr        <= '0;
         busy       <= 1'b0;
         preview_en <= 1'b0;
         cur_x_q    <= DEF_X;
         cur_y_q    <= DEF_Y;
         cur_r_q    <= R_DEF;
         cur_k_q    <= K_DEF;
         btn_q      <= '0;
         edit_q     <= 1'b0;
         hold_cnt   <= '0;
         rep_cnt    <= '0;
         for (int i = 0; i < N_SLOTS; i++) begin
            slot_x[i] <= '0;
            slot_y[i] <= '0;
            slot_r[i] <= R_DEF;
            slot_k[i] <= K_DEF;
         end
      end else begin
         btn_q      <= btn_now;
         edit_q     <= edit_en;
         preview_en <= edit_en & ((state == S_ADD) | (state == S_SELECT));

         if (!dir_held)
            hold_cnt <= '0;
         else if (hold_cnt != '1)
            hold_cnt <= hold_cnt + HOLD_W'(1);

         if (!dir_held || dir_rise || rep_tick)
            rep_cnt <= '0;
         else
            rep_cnt <= rep_cnt + REP_W'(1);

         if (edit_fall) begin
            state      <= S_IDLE;
            lens_count <= '0;
            sel_idx    <= '0;
            ptr        <= '0;
            busy       <= 1'b0;
            for (int i = 0; i < N_SLOTS; i++) begin
               slot_x[i] <= '0;
               slot_y[i] <= '0;
               slot_r[i] <= R_DEF;
               slot_k[i] <= K_DEF;
            end
         end else begin
            case (state)
               S_IDLE: begin
                  if (edit_rise) begin
                     state   <= S_ADD;
                     cur_x_q <= DEF_X;
                     cur_y_q <= DEF_Y;
                     cur_r_q <= R_DEF;
                     cur_k_q <= K_DEF;
                  end
               end
               S_ADD: begin
                  cur_x_q <= ed_x;
                  cur_y_q <= ed_y;
                  cur_r_q <= ed_r;
                  cur_k_q <= ed_k;
                  if (del_ok) begin
                     slot_x[cnt_last] <= '0;
                     slot_y[cnt_last] <= '0;
                     slot_r[cnt_last] <= R_DEF;
                     slot_k[cnt_last] <= K_DEF;
                     lens_count       <= cnt_m1;
                  end else if (c_ok) begin
                     slot_x[cnt_lo] <= cur_x_q;
                     slot_y[cnt_lo] <= cur_y_q;
                     slot_r[cnt_lo] <= cur_r_q;
                     slot_k[cnt_lo] <= cur_k_q;
                     lens_count     <= lens_count + CNT_W'(1);
                     cur_x_q        <= DEF_X;
                     cur_y_q        <= DEF_Y;
                     cur_r_q        <= R_DEF;
                     cur_k_q        <= K_DEF;
                  end
                  if (sel_mode && add_cnt_nxt != '0) begin
                     state   <= S_SELECT;
                     sel_idx <= SEL_W'(add_cnt_nxt - CNT_W'(1));
                  end
               end
               S_SELECT: begin
                  if (!sel_mode) begin
                     state <= S_ADD;
                  end else if (rise[5]) begin
                     state <= S_COMPACT;
                     ptr   <= sel_idx;
                     busy  <= 1'b1;
                  end else begin
                     slot_x[sel_idx] <= ed_x;
                     slot_y[sel_idx] <= ed_y;
                     slot_r[sel_idx] <= ed_r;
                     slot_k[sel_idx] <= ed_k;
                     if (rise[4])
                        sel_idx <= (sel_ext == cnt_m1) ? '0 : sel_idx + SEL_W'(1);
                  end
               end
               S_COMPACT: begin
                  if (ptr_ext < cnt_m1) begin
                     slot_x[ptr] <= slot_x[ptr + SEL_W'(1)];
                     slot_y[ptr] <= slot_y[ptr + SEL_W'(1)];
                     slot_r[ptr] <= slot_r[ptr + SEL_W'(1)];
                     slot_k[ptr] <= slot_k[ptr + SEL_W'(1)];
                     ptr         <= ptr + SEL_W'(1);
                  end else begin
                     // last slot now holds a duplicate (or the deleted lens); drop it
                     slot_x[cnt_last] <= '0;
                     slot_y[cnt_last] <= '0;
                     slot_r[cnt_last] <= R_DEF;
                     slot_k[cnt_last] <= K_DEF;
                     lens_count       <= cnt_m1;
                     busy             <= 1'b0;
                     if (cnt_m1 == '0)
                        sel_idx <= '0;
                     else if (sel_ext >= cnt_m1)
                        sel_idx <= SEL_W'(cnt_m1 - CNT_W'(1));
                     state <= (cnt_m1 != '0) ? S_SELECT : S_ADD;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   for (genvar i = 0; i < N_SLOTS; i++) begin : g_flat
      assign lens_x[i*X_W +: X_W] = slot_x[i];
      assign lens_y[i*Y_W +: Y_W] = slot_y[i];
      assign lens_r[i*8 +: 8]     = slot_r[i];
      assign lens_k[i*8 +: 8]     = slot_k[i];
   end

endmodule

// File: tb/tb_lens_slot_manager.sv
// Bench for lens_slot_manager: directed stimulus queues expected values, a negedge monitor compares them.
// Latency: checks sampled at negedge after each stimulus step; immediate checks sampled 1 time unit after posedge.
// Backpressure: none; waits on busy are bounded and report expiry as a failure.
module tb_lens_slot_manager;

    localparam int N_SLOTS = 8;
    localparam int X_W     = 9;
    localparam int Y_W     = 8;
    localparam int CNT_W   = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic edit_en = 1'b0, sel_mode = 1'b0;
    logic [1:0] field_sel = 2'd0;
    logic btn_u = 0, btn_d = 0, btn_l = 0, btn_r = 0, btn_c = 0, btn_del = 0;
    logic [X_W-1:0] cur_x;
    logic [Y_W-1:0] cur_y;
    logic [7:0] cur_r, cur_k;
    logic preview_en, full, busy;
    logic [2:0] sel_idx;
    logic [CNT_W-1:0] lens_count;
    logic [N_SLOTS*X_W-1:0] lens_x;
    logic [N_SLOTS*Y_W-1:0] lens_y;
    logic [N_SLOTS*8-1:0] lens_r, lens_k;

    lens_slot_manager #(
        .N_SLOTS(N_SLOTS), .REP_T0(8), .REP_T1(4), .REP_T2(2), .HOLD1(40), .HOLD2(80)
    ) dut (
        .clk(clk), .reset(reset), .edit_en(edit_en), .sel_mode(sel_mode), .field_sel(field_sel),
        .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r), .btn_c(btn_c), .btn_del(btn_del),
        .cur_x(cur_x), .cur_y(cur_y), .cur_r(cur_r), .cur_k(cur_k), .preview_en(preview_en),
        .sel_idx(sel_idx), .lens_count(lens_count), .lens_x(lens_x), .lens_y(lens_y),
        .lens_r(lens_r), .lens_k(lens_k), .full(full), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    sig;
        int    val;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int checks = 0;
    int errors = 0;

    // signal codes: 0..8 scalar outputs, 100+i/200+i/300+i/400+i slot i x/y/r/k
    function automatic int get_sig(int s);
        int i;
        i = s % 100;
        case (s / 100)
            1: return int'(lens_x[i*X_W +: X_W]);
            2: return int'(lens_y[i*Y_W +: Y_W]);
            3: return int'(lens_r[i*8 +: 8]);
            4: return int'(lens_k[i*8 +: 8]);
            default: ;
        endcase
        case (s)
            0: return int'(cur_x);
            1: return int'(cur_y);
            2: return int'(cur_r);
            3: return int'(cur_k);
            4: return int'(preview_en);
            5: return int'(sel_idx);
            6: return int'(lens_count);
            7: return int'(full);
            8: return int'(busy);
            default: return -1;
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (get_sig(e.sig) !== e.val) begin
                errors++;
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", e.name, get_sig(e.sig), e.val, $time);
            end
        end
    end

    task automatic want(input string n, input int s, input int v);
        exp_t x;
        x.name = n;
        x.sig  = s;
        x.val  = v;
        sb.push_back(x);
    endtask

    task automatic chk_now(input string n, input int s, input int v);
        checks++;
        if (get_sig(s) !== v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", n, get_sig(s), v, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_not_busy(input string n, input int max_cycles);
        int k;
        k = 0;
        while (busy && k < max_cycles) begin
            tick(1);
            k++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s: busy still high after %0d cycles (t=%0t)", n, max_cycles, $time);
        end
    endtask

    // 0=u 1=d 2=l 3=r 4=c 5=del
    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btn_u = v;
            1: btn_d = v;
            2: btn_l = v;
            3: btn_r = v;
            4: btn_c = v;
            default: btn_del = v;
        endcase
    endtask

    task automatic press(input int b, input int times);
        for (int i = 0; i < times; i++) begin
            set_btn(b, 1'b1);
            tick(1);
            set_btn(b, 1'b0);
            tick(1);
        end
    endtask

    // drive cursor x to 0 with auto-repeat, step right to target, store
    task automatic store_x(input int target, input bit chk_clamp);
        btn_l = 1'b1;
        tick(500);
        btn_l = 1'b0;
        tick(2);
        if (chk_clamp) begin
            want("cursor_x_floor", 0, 0);
            press(2, 1);
            want("cursor_x_stays_0", 0, 0);
            want("cursor_y_untouched", 1, 120);
        end
        press(3, target);
        press(4, 1);
    endtask

    initial begin
        tick(3);
        reset = 1'b0;
        tick(1);
        chk_now("rst_now_count", 6, 0);
        chk_now("rst_now_busy", 8, 0);
        chk_now("rst_now_cur_x", 0, 160);
        want("rst_count", 6, 0);
        want("rst_sel", 5, 0);
        want("rst_cur_x", 0, 160);
        want("rst_cur_y", 1, 120);
        want("rst_cur_r", 2, 30);
        want("rst_cur_k", 3, 40);
        want("rst_preview", 4, 0);
        want("rst_full", 7, 0);
        want("rst_busy", 8, 0);
        want("rst_slot3_r", 303, 30);
        want("rst_slot3_k", 403, 40);

        // fill the table with default lenses
        edit_en = 1'b1;
        tick(2);
        want("preview_on", 4, 1);
        press(4, 8);
        want("fill_count", 6, 8);
        want("fill_full", 7, 1);
        want("fill_s0_x", 100, 160);
        want("fill_s0_y", 200, 120);
        want("fill_s0_r", 300, 30);
        want("fill_s7_x", 107, 160);
        want("fill_s7_k", 407, 40);
        press(4, 1);
        want("ninth_c_count", 6, 8);

        edit_en = 1'b0;
        tick(1);
        want("idle_count", 6, 0);
        want("idle_full", 7, 0);
        want("idle_preview", 4, 0);
        want("idle_s7_x", 107, 0);
        want("idle_s7_r", 307, 30);
        edit_en = 1'b1;
        tick(2);

        // auto-repeat on R: period 8 until hold 40, then 4 until 80, then 2
        field_sel = 2'd1;
        btn_u = 1'b1;
        tick(1);
        want("rep_first_step", 2, 31);
        tick(7);
        want("rep_before_t0", 2, 31);
        tick(1);
        want("rep_at_t0", 2, 32);
        tick(35);
        want("rep_before_h1", 2, 36);
        tick(1);
        want("rep_at_h1", 2, 37);
        tick(3);
        want("rep_mid_gap", 2, 37);
        tick(1);
        want("rep_mid_step", 2, 38);
        tick(32);
        want("rep_at_h2", 2, 46);
        tick(1);
        want("rep_fast_gap", 2, 46);
        tick(1);
        want("rep_fast_step", 2, 47);
        tick(218);
        want("r_sat_max", 2, 120);
        btn_u = 1'b0;
        tick(2);
        btn_d = 1'b1;
        tick(320);
        want("r_sat_min", 2, 5);
        btn_d = 1'b0;
        tick(2);

        // four lenses at x=10,20,30,40
        field_sel = 2'd0;
        store_x(10, 1'b1);
        store_x(20, 1'b0);
        store_x(30, 1'b0);
        store_x(40, 1'b0);
        want("four_count", 6, 4);
        want("four_s1_x", 101, 20);
        want("four_s3_x", 103, 40);

        sel_mode = 1'b1;
        tick(1);
        want("select_entry_idx", 5, 3);
        want("select_mirror_x", 0, 40);
        press(4, 2);
        want("select_idx1", 5, 1);
        want("select_idx1_x", 0, 20);

        // delete idx 1: two shifts plus one final cycle
        btn_del = 1'b1;
        tick(1);
        want("compact_busy0", 8, 1);
        btn_del = 1'b0;
        tick(1);
        want("compact_busy1", 8, 1);
        tick(1);
        want("compact_busy2", 8, 1);
        tick(1);
        want("compact_done", 8, 0);
        want("compact_count", 6, 3);
        want("compact_sel", 5, 1);
        want("compact_s0_x", 100, 10);
        want("compact_s1_x", 101, 30);
        want("compact_s2_x", 102, 40);
        want("compact_s3_x", 103, 0);
        want("compact_s3_r", 303, 30);
        wait_not_busy("compact_wait", 10);

        // edit slot 2 in place, then wrap the selection
        press(4, 1);
        want("sel_idx2", 5, 2);
        press(3, 5);
        want("edit_s2_x", 102, 45);
        want("edit_cur_x", 0, 45);
        want("edit_s1_x_kept", 101, 30);
        press(4, 1);
        want("sel_wrap", 5, 0);

        // edit_en drops while compacting
        btn_del = 1'b1;
        tick(1);
        want("abort_busy", 8, 1);
        btn_del = 1'b0;
        edit_en = 1'b0;
        sel_mode = 1'b0;
        tick(1);
        want("abort_count", 6, 0);
        want("abort_busy_clr", 8, 0);
        want("abort_preview", 4, 0);
        want("abort_s0_x", 100, 0);
        want("abort_s2_x", 102, 0);
        want("abort_s1_k", 401, 40);

        // del and c rising together: del wins
        edit_en = 1'b1;
        tick(2);
        press(4, 2);
        want("two_count", 6, 2);
        press(3, 3);
        want("cursor_163", 0, 163);
        btn_c = 1'b1;
        btn_del = 1'b1;
        tick(1);
        btn_c = 1'b0;
        btn_del = 1'b0;
        tick(1);
        want("delc_count", 6, 1);
        want("delc_s1_x", 101, 0);
        want("delc_s0_x", 100, 160);
        want("delc_cursor_kept", 0, 163);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
